// File: rtl/riscv_rf_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package riscv_rf_mp_pkg;

   typedef logic [4:0] rsd_t;

   localparam rsd_t zero = 5'd0;

   localparam int unsigned RF_XLEN   = 32;
   localparam int unsigned RF_NREGS  = 32;
   // Widest write-port count supported; narrower configs pad with disabled ports.
   localparam int unsigned RF_MAX_WR = 2;

   typedef struct packed {
      logic hit;
      logic port;
   } wr_win_t;

   // Highest-numbered enabled port targeting idx wins; data is selected by the caller.
   function automatic wr_win_t wr_win(input rsd_t                        idx,
                                      input logic [RF_MAX_WR-1:0][4:0] dst,
                                      input logic [RF_MAX_WR-1:0]      we);
      wr_win_t r;
      r = '0;
      for (int w = 0; w < RF_MAX_WR; w++) begin
         if (we[w] && (dst[w] == idx)) begin
            r.hit  = 1'b1;
            r.port = w[0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/riscv_rf_rdport.sv
// One synchronous read port: latched index, stall hold, bypass and stall refresh.
module riscv_rf_rdport
   import riscv_rf_mp_pkg::*;
#(
   parameter int unsigned XLEN     = RF_XLEN,
   parameter int unsigned NREGS    = RF_NREGS,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 stall_i,
   input  logic [4:0]                           src_i,
   input  logic [NREGS-1:0][XLEN-1:0]           regs_i,
   input  logic [RF_MAX_WR-1:0][4:0]            wr_dst_i,
   input  logic [RF_MAX_WR-1:0]                 wr_we_i,
   input  logic [RF_MAX_WR-1:0][XLEN-1:0]       wr_data_i,
   output logic [XLEN-1:0]                      rd_q_o
);

   localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

   rsd_t            src_q, src_d;
   logic [XLEN-1:0] rd_q, rd_d;
   wr_win_t         win;

   // Next index/data: hold and refresh under stall, otherwise capture a fresh read.
   always_comb begin
      src_d = src_q;
      rd_d  = rd_q;
      win   = '0;
      if (stall_i) begin
         // Refresh applies even with BYPASS=0 so a held operand never goes stale.
         win = wr_win(src_q, wr_dst_i, wr_we_i);
         if (win.hit) rd_d = wr_data_i[win.port];
      end else begin
         src_d = src_i;
         win   = wr_win(src_i, wr_dst_i, wr_we_i);
         if (((ZERO_REG != 0) && (src_i == zero)) || (32'(src_i) >= NREGS)) begin
            rd_d = '0;
         end else if ((BYPASS != 0) && win.hit) begin
            rd_d = wr_data_i[win.port];
         end else begin
            rd_d = regs_i[src_i[IdxW-1:0]];
         end
      end
   end

   // Index and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         src_q <= '0;
         rd_q  <= '0;
      end else begin
         src_q <= src_d;
         rd_q  <= rd_d;
      end
   end

   assign rd_q_o = rd_q;

endmodule

// File: rtl/riscv_rf_mp.sv
// Multi-port register file: storage array, write resolution and NRD read ports.
module riscv_rf_mp
   import riscv_rf_mp_pkg::*;
#(
   parameter int unsigned XLEN     = RF_XLEN,
   parameter int unsigned NREGS    = RF_NREGS,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall_i,
   input  logic [NRD-1:0][4:0]            rf_src_i,
   output logic [NRD-1:0][XLEN-1:0]       rf_src_q_o,
   input  logic [NWR-1:0][4:0]            rf_dst_i,
   input  logic [NWR-1:0][XLEN-1:0]       rf_dst_d_i,
   input  logic [NWR-1:0]                 rf_we_i,
   output logic [NREGS-1:0][XLEN-1:0]     rf_o
);

   logic [NREGS-1:0][XLEN-1:0]     regs_q, regs_d;
   logic [RF_MAX_WR-1:0][4:0]      dst_pad;
   logic [RF_MAX_WR-1:0]           we_pad;
   logic [RF_MAX_WR-1:0][XLEN-1:0] data_pad;
   wr_win_t                        win;

   // Effective write enables: illegal indices (x0 when hardwired, >= NREGS) are dropped.
   always_comb begin
      dst_pad  = '0;
      we_pad   = '0;
      data_pad = '0;
      for (int w = 0; w < int'(NWR); w++) begin
         dst_pad[w]  = rf_dst_i[w];
         data_pad[w] = rf_dst_d_i[w];
         we_pad[w]   = rf_we_i[w] && (32'(rf_dst_i[w]) < NREGS) &&
                       !((ZERO_REG != 0) && (rf_dst_i[w] == zero));
      end
   end

   // Array next state; writes are not gated by stall since WB runs independently.
   always_comb begin
      regs_d = regs_q;
      win    = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         win = wr_win(rsd_t'(i), dst_pad, we_pad);
         if (win.hit) regs_d[i] = data_pad[win.port];
      end
   end

   // Storage array with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) regs_q <= '0;
      else      regs_q <= regs_d;
   end

   for (genvar r = 0; r < NRD; r++) begin : g_rd
      riscv_rf_rdport #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .clk_i     (clk),
         .rst_ni    (rst),
         .stall_i   (stall_i),
         .src_i     (rf_src_i[r]),
         .regs_i    (regs_q),
         .wr_dst_i  (dst_pad),
         .wr_we_i   (we_pad),
         .wr_data_i (data_pad),
         .rd_q_o    (rf_src_q_o[r])
      );
   end

   assign rf_o = regs_q;

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Directed bench: one BYPASS=1 and one BYPASS=0 instance share the same stimulus.
module tb_riscv_rf_mp;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic [1:0][4:0]   src;
   logic [1:0][4:0]   dst;
   logic [1:0][31:0]  wd;
   logic [1:0]        we;
   logic [1:0][31:0]  qa, qb;
   logic [31:0][31:0] rfa, rfb;

   int nchk  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   riscv_rf_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
   ) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .rf_src_i   (src),
      .rf_src_q_o (qa),
      .rf_dst_i   (dst),
      .rf_dst_d_i (wd),
      .rf_we_i    (we),
      .rf_o       (rfa)
   );

   riscv_rf_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .rf_src_i   (src),
      .rf_src_q_o (qb),
      .rf_dst_i   (dst),
      .rf_dst_d_i (wd),
      .rf_we_i    (we),
      .rf_o       (rfb)
   );

   typedef struct {
      logic        rst, stall;
      logic [4:0]  s0, s1;
      logic        we0; logic [4:0] d0; logic [31:0] w0;
      logic        we1; logic [4:0] d1; logic [31:0] w1;
      logic [31:0] ea0, ea1, eb0, eb1;
   } vec_t;

   function automatic vec_t mk(logic r, logic st, logic [4:0] s0, logic [4:0] s1,
                               logic e0, logic [4:0] d0, logic [31:0] w0,
                               logic e1, logic [4:0] d1, logic [31:0] w1,
                               logic [31:0] ea0, logic [31:0] ea1,
                               logic [31:0] eb0, logic [31:0] eb1);
      vec_t v;
      v.rst = r; v.stall = st; v.s0 = s0; v.s1 = s1;
      v.we0 = e0; v.d0 = d0; v.w0 = w0; v.we1 = e1; v.d1 = d1; v.w1 = w1;
      v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive at negedge, let one posedge happen, come back to the next negedge to sample.
   task automatic apply(input vec_t v);
      rst = v.rst; stall = v.stall; src[0] = v.s0; src[1] = v.s1;
      we[0] = v.we0; dst[0] = v.d0; wd[0] = v.w0;
      we[1] = v.we1; dst[1] = v.d1; wd[1] = v.w1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_q(input string name, input vec_t v);
      chk({name, ".a0"}, qa[0], v.ea0);
      chk({name, ".a1"}, qa[1], v.ea1);
      chk({name, ".b0"}, qb[0], v.eb0);
      chk({name, ".b1"}, qb[1], v.eb1);
   endtask

   vec_t tbl[11];
   vec_t seq[8];

   initial begin
      rst = 1'b0; stall = 1'b0; src = '0; dst = '0; wd = '0; we = '0;
      @(negedge clk);

      //            rst st s0 s1  we0 d0 w0            we1 d1 w1            ea0 ea1 eb0 eb1
      tbl[0]  = mk(0, 0, 0, 0,   0, 0, 0,             0, 0, 0,             0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,   0, 0, 0,             0, 0, 0,             0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 5, 0,   0, 0, 0,             0, 0, 0,             0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 5, 0,   1, 3, 32'hDEADBEEF,  0, 0, 0,             0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 3, 0,   1, 0, 32'h1234,      0, 0, 0,
                   32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
      tbl[5]  = mk(1, 0, 0, 3,   0, 0, 0,             0, 0, 0,
                   0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
      tbl[6]  = mk(1, 0, 7, 7,   0, 0, 0,             1, 7, 32'hA5A5A5A5,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
      tbl[7]  = mk(1, 0, 4, 7,   1, 4, 32'h100,       1, 4, 32'h200,
                   32'h200, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
      tbl[8]  = mk(1, 0, 4, 0,   1, 0, 32'h111,       1, 0, 32'h222,
                   32'h200, 0, 32'h200, 0);
      tbl[9]  = mk(1, 0, 31, 30, 1, 31, 32'h31,       1, 30, 32'h30,
                   32'h31, 32'h30, 0, 0);
      tbl[10] = mk(1, 0, 31, 30, 0, 0, 0,             0, 0, 0,
                   32'h31, 32'h30, 32'h31, 32'h30);

      for (int i = 0; i < 11; i++) begin
         apply(tbl[i]);
         chk($sformatf("vec%0d", i), qa[0], tbl[i].ea0);
         chk($sformatf("vec%0d.a1", i), qa[1], tbl[i].ea1);
         chk($sformatf("vec%0d.b0", i), qb[0], tbl[i].eb0);
         chk($sformatf("vec%0d.b1", i), qb[1], tbl[i].eb1);
         if (i == 2) begin
            for (int k = 0; k < 32; k++) begin
               chk($sformatf("rst_rf_a[%0d]", k), rfa[k], 32'h0);
            end
         end
      end

      chk("rf_a[0]", rfa[0], 32'h0);
      chk("rf_b[0]", rfb[0], 32'h0);
      chk("rf_a[3]", rfa[3], 32'hDEADBEEF);
      chk("rf_a[4]", rfa[4], 32'h200);
      chk("rf_b[4]", rfb[4], 32'h200);
      chk("rf_a[7]", rfa[7], 32'hA5A5A5A5);
      chk("rf_b[31]", rfb[31], 32'h31);

      // Stall hold with live refresh; x1 written during stall must not be captured.
      seq[0] = mk(1, 0, 0, 3, 1, 9, 32'h11, 0, 0, 0,
                  0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
      seq[1] = mk(1, 0, 9, 3, 0, 0, 0, 0, 0, 0,
                  32'h11, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF);
      seq[2] = mk(1, 1, 1, 1, 1, 1, 32'h77, 0, 0, 0,
                  32'h11, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF);
      seq[3] = mk(1, 1, 1, 1, 1, 9, 32'h22, 0, 0, 0,
                  32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF);
      seq[4] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0,
                  32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF);
      seq[5] = mk(1, 0, 1, 9, 0, 0, 0, 0, 0, 0,
                  32'h77, 32'h22, 32'h77, 32'h22);
      // Reset dominates a concurrent write and stall.
      seq[6] = mk(0, 1, 6, 6, 1, 6, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      seq[7] = mk(1, 0, 6, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         apply(seq[i]);
         chk_q($sformatf("seq%0d", i), seq[i]);
         if (i == 6) begin
            chk("midrst_rf_a[6]", rfa[6], 32'h0);
            chk("midrst_rf_b[9]", rfb[9], 32'h0);
            chk("midrst_rf_a[3]", rfa[3], 32'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
